// File: rtl/wb_cmd_master.sv
// Single-beat pipelined Wishbone initiator: command stream in, one bus cycle per command, response stream out.
// Optional statistics counters are built only when WB_CMD_MASTER_STATS_EN is defined.
module wb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  WB_CYC,
    output logic                  WB_STB,
    output logic                  WB_WE,
    output logic [ADDR_WIDTH-1:0] WB_ADDR,
    output logic [DATA_WIDTH-1:0] WB_WDATA,
    output logic                  WB_SEL,
    input  logic                  WB_STALL,
    input  logic                  WB_ACK,
    input  logic [DATA_WIDTH-1:0] WB_RDATA,
    input  logic                  WB_ERR,
    output logic [15:0]           STAT_XFERS,
    output logic [7:0]            STAT_ERRS,
    output logic [7:0]            STAT_TIMEOUTS
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_CNT_WIDTH-1:0] TO_LAST =
        TO_CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state_reg;
    logic [TO_CNT_WIDTH-1:0] to_cnt_reg;
    logic                    done;
    logic                    to_fire;

    // A termination only counts once the strobe has been accepted (REQ with no stall) or in WAIT.
    always_comb begin
        done    = 1'b0;
        to_fire = 1'b0;
        case (state_reg)
            REQ:     done = !WB_STALL && (WB_ACK || WB_ERR);
            WAIT:    done = WB_ACK || WB_ERR;
            default: done = 1'b0;
        endcase
        if ((state_reg == REQ || state_reg == WAIT) && !done)
            to_fire = TO_EN && (to_cnt_reg == TO_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= IDLE;
            to_cnt_reg  <= '0;
            CMD_READY   <= 1'b1;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            WB_CYC      <= 1'b0;
            WB_STB      <= 1'b0;
            WB_WE       <= 1'b0;
            WB_ADDR     <= '0;
            WB_WDATA    <= '0;
            WB_SEL      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (CMD_VALID) begin
                        WB_WE      <= CMD_WE;
                        WB_ADDR    <= CMD_ADDR;
                        WB_WDATA   <= CMD_WDATA;
                        WB_SEL     <= 1'b1;
                        WB_CYC     <= 1'b1;
                        WB_STB     <= 1'b1;
                        CMD_READY  <= 1'b0;
                        to_cnt_reg <= '0;
                        state_reg  <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (done || to_fire) begin
                        WB_CYC      <= 1'b0;
                        WB_STB      <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        RSP_TIMEOUT <= to_fire;
                        RSP_ERR     <= to_fire || WB_ERR;
                        // Only a clean read ACK returns bus data; everything else reports zero.
                        RSP_RDATA   <= (done && !WB_ERR && !WB_WE) ? WB_RDATA : '0;
                        state_reg   <= RESP;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_CNT_WIDTH'(1);
                        if (state_reg == REQ && !WB_STALL) begin
                            WB_STB    <= 1'b0;
                            state_reg <= WAIT;
                        end
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef WB_CMD_MASTER_STATS_EN
    logic [15:0] xfers_reg;
    logic [7:0]  errs_reg;
    logic [7:0]  timeouts_reg;

    // Counters saturate so a long soak never wraps back to a misleading small value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            xfers_reg    <= '0;
            errs_reg     <= '0;
            timeouts_reg <= '0;
        end else if (done || to_fire) begin
            if (xfers_reg != '1)
                xfers_reg <= xfers_reg + 16'd1;
            if (done && WB_ERR && errs_reg != '1)
                errs_reg <= errs_reg + 8'd1;
            if (to_fire && timeouts_reg != '1)
                timeouts_reg <= timeouts_reg + 8'd1;
        end
    end

    assign STAT_XFERS    = xfers_reg;
    assign STAT_ERRS     = errs_reg;
    assign STAT_TIMEOUTS = timeouts_reg;
`else
    assign STAT_XFERS    = '0;
    assign STAT_ERRS     = '0;
    assign STAT_TIMEOUTS = '0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: inputs driven and outputs sampled on the falling edge.
module tb_wb_cmd_master;

`ifdef WB_CMD_MASTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        wb_cyc, wb_stb, wb_we, wb_sel;
    logic [31:0] wb_addr;
    logic [7:0]  wb_wdata;
    logic        wb_stall = 1'b0;
    logic        wb_ack = 1'b0;
    logic [7:0]  wb_rdata = '0;
    logic        wb_err = 1'b0;
    logic [15:0] stat_xfers;
    logic [7:0]  stat_errs;
    logic [7:0]  stat_timeouts;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8), .TO_CNT_WIDTH(8)
    ) dut (
        .CLK(clk), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WE(cmd_we),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
        .RSP_ERR(rsp_err), .RSP_TIMEOUT(rsp_timeout),
        .WB_CYC(wb_cyc), .WB_STB(wb_stb), .WB_WE(wb_we), .WB_ADDR(wb_addr),
        .WB_WDATA(wb_wdata), .WB_SEL(wb_sel), .WB_STALL(wb_stall), .WB_ACK(wb_ack),
        .WB_RDATA(wb_rdata), .WB_ERR(wb_err),
        .STAT_XFERS(stat_xfers), .STAT_ERRS(stat_errs), .STAT_TIMEOUTS(stat_timeouts)
    );

    // Presents one command for exactly one accept edge; returns at the first STB cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [7:0] wdata);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready); end
        tests++; if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 4'b0) begin fails++; $display("FAIL reset_wb got %b expected 0000", {wb_cyc, wb_stb, wb_we, wb_sel}); end
        tests++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 11'b0) begin fails++; $display("FAIL reset_rsp got %h expected 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
        tests++; if ({stat_xfers, stat_errs, stat_timeouts} !== 32'b0) begin fails++; $display("FAIL reset_stats got %h expected 0", {stat_xfers, stat_errs, stat_timeouts}); end
        $display("[TB] reset done");
    endtask

    task automatic test_write();
        issue(1'b1, 32'h3000_0010, 8'h5A);
        // cycle 1 after accept: strobe out, slave accepts
        tests++; if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 4'b1111) begin fails++; $display("FAIL wr_strobe got %b expected 1111", {wb_cyc, wb_stb, wb_we, wb_sel}); end
        tests++; if (wb_addr !== 32'h3000_0010 || wb_wdata !== 8'h5A) begin fails++; $display("FAIL wr_bus got %h/%h expected 30000010/5a", wb_addr, wb_wdata); end
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL wr_cmd_ready got %b expected 0", cmd_ready); end
        @(negedge clk);
        tests++; if ({wb_cyc, wb_stb, rsp_valid} !== 3'b100) begin fails++; $display("FAIL wr_wait got %b expected 100", {wb_cyc, wb_stb, rsp_valid}); end
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        tests++; if ({rsp_valid, rsp_err, rsp_timeout, wb_cyc} !== 4'b1000) begin fails++; $display("FAIL wr_rsp got %b expected 1000", {rsp_valid, rsp_err, rsp_timeout, wb_cyc}); end
        tests++; if (rsp_rdata !== 8'h00 || wb_wdata !== 8'h5A || wb_we !== 1'b1) begin fails++; $display("FAIL wr_rdata got %h/%h expected 00/5a", rsp_rdata, wb_wdata); end
        handshake();
        tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin fails++; $display("FAIL wr_idle got %b expected 10", {cmd_ready, rsp_valid}); end
        $display("[TB] write 30000010 <= 5a complete");
    endtask

    task automatic test_stall_read();
        issue(1'b0, 32'h3000_0004, 8'h00);
        for (int i = 0; i < 3; i++) begin
            wb_stall = 1'b1;
            // an ACK during a stalled strobe must be ignored
            wb_ack = (i == 1); wb_rdata = (i == 1) ? 8'h11 : 8'h00;
            tests++; if ({wb_cyc, wb_stb, wb_we, rsp_valid} !== 4'b1100 || wb_addr !== 32'h3000_0004) begin fails++; $display("FAIL rd_stall%0d got %b/%h expected 1100/30000004", i, {wb_cyc, wb_stb, wb_we, rsp_valid}, wb_addr); end
            @(negedge clk);
        end
        tests++; if ({wb_cyc, wb_stb, rsp_valid} !== 3'b110 || wb_addr !== 32'h3000_0004) begin fails++; $display("FAIL rd_accept got %b/%h expected 110/30000004", {wb_cyc, wb_stb, rsp_valid}, wb_addr); end
        wb_stall = 1'b0; wb_ack = 1'b1; wb_rdata = 8'hC3;
        @(negedge clk);
        wb_ack = 1'b0; wb_rdata = 8'h00;
        tests++; if ({rsp_valid, rsp_err, rsp_timeout, wb_cyc, wb_stb} !== 5'b10000) begin fails++; $display("FAIL rd_rsp got %b expected 10000", {rsp_valid, rsp_err, rsp_timeout, wb_cyc, wb_stb}); end
        tests++; if (rsp_rdata !== 8'hC3) begin fails++; $display("FAIL rd_rdata got %h expected c3", rsp_rdata); end
        handshake();
        $display("[TB] read 30000004 => %h complete", 8'hC3);
    endtask

    task automatic test_err();
        issue(1'b0, 32'h3000_0008, 8'h00);
        wb_ack = 1'b1; wb_err = 1'b1; wb_rdata = 8'hFF;
        @(negedge clk);
        wb_ack = 1'b0; wb_err = 1'b0; wb_rdata = 8'h00;
        tests++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin fails++; $display("FAIL err_flags got %b expected 110", {rsp_valid, rsp_err, rsp_timeout}); end
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL err_rdata got %h expected 00", rsp_rdata); end
        tests++; if (stat_errs !== (STATS ? 8'd1 : 8'd0) || stat_xfers !== (STATS ? 16'd3 : 16'd0)) begin fails++; $display("FAIL err_stats got %0d/%0d expected %0d/%0d", stat_errs, stat_xfers, STATS ? 1 : 0, STATS ? 3 : 0); end
        handshake();
        $display("[TB] read 30000008 terminated by ERR");
    endtask

    task automatic test_timeout();
        issue(1'b0, 32'h3000_000C, 8'h00);
        // now in first STB cycle T; slave stays silent
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            tests++; if ({wb_cyc, rsp_valid} !== 2'b10) begin fails++; $display("FAIL to_pending%0d got %b expected 10", k, {wb_cyc, rsp_valid}); end
        end
        @(negedge clk);
        tests++; if ({wb_cyc, wb_stb, rsp_valid, rsp_err, rsp_timeout} !== 5'b00111) begin fails++; $display("FAIL to_fire got %b expected 00111", {wb_cyc, wb_stb, rsp_valid, rsp_err, rsp_timeout}); end
        tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL to_rdata got %h expected 00", rsp_rdata); end
        @(negedge clk);
        wb_ack = 1'b1; wb_rdata = 8'h77;
        @(negedge clk);
        wb_ack = 1'b0; wb_rdata = 8'h00;
        tests++; if ({rsp_valid, rsp_err, rsp_timeout, wb_cyc} !== 4'b1110 || rsp_rdata !== 8'h00) begin fails++; $display("FAIL to_late_ack got %b/%h expected 1110/00", {rsp_valid, rsp_err, rsp_timeout, wb_cyc}, rsp_rdata); end
        tests++; if (stat_timeouts !== (STATS ? 8'd1 : 8'd0) || stat_xfers !== (STATS ? 16'd4 : 16'd0) || stat_errs !== (STATS ? 8'd1 : 8'd0)) begin fails++; $display("FAIL to_stats got %0d/%0d/%0d expected %0d/%0d/%0d", stat_timeouts, stat_xfers, stat_errs, STATS ? 1 : 0, STATS ? 4 : 0, STATS ? 1 : 0); end
        handshake();
        $display("[TB] read 3000000c timed out");
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 32'h3000_0020, 8'h11);
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h3000_0024; cmd_wdata = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tests++; if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, wb_cyc} !== 5'b10000 || rsp_rdata !== 8'h00) begin fails++; $display("FAIL bp_hold%0d got %b/%h expected 10000/00", i, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, wb_cyc}, rsp_rdata); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++; if ({cmd_ready, rsp_valid, wb_cyc} !== 3'b100) begin fails++; $display("FAIL bp_ready got %b expected 100", {cmd_ready, rsp_valid, wb_cyc}); end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++; if ({wb_cyc, wb_stb} !== 2'b11 || wb_wdata !== 8'h22 || wb_addr !== 32'h3000_0024) begin fails++; $display("FAIL bp_next got %b/%h/%h expected 11/22/30000024", {wb_cyc, wb_stb}, wb_wdata, wb_addr); end
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_second_rsp got %b expected 1", rsp_valid); end
        handshake();
        $display("[TB] back-to-back writes 30000020/30000024 complete");
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h3000_0030, 8'h00);
        @(negedge clk);
        tests++; if ({wb_cyc, wb_stb} !== 2'b10) begin fails++; $display("FAIL rm_wait got %b expected 10", {wb_cyc, wb_stb}); end
        rst = 1'b1; wb_ack = 1'b1; wb_rdata = 8'h99;
        @(negedge clk);
        rst = 1'b0; wb_ack = 1'b0; wb_rdata = 8'h00;
        tests++; if ({wb_cyc, wb_stb, rsp_valid, cmd_ready} !== 4'b0001) begin fails++; $display("FAIL rm_after got %b expected 0001", {wb_cyc, wb_stb, rsp_valid, cmd_ready}); end
        tests++; if ({stat_xfers, stat_errs, stat_timeouts} !== 32'b0) begin fails++; $display("FAIL rm_stats got %h expected 0", {stat_xfers, stat_errs, stat_timeouts}); end
        @(negedge clk);
        tests++; if ({rsp_valid, wb_cyc} !== 2'b00) begin fails++; $display("FAIL rm_discard got %b expected 00", {rsp_valid, wb_cyc}); end
        $display("[TB] reset during WAIT handled");
    endtask

    initial begin
        test_reset();
        test_write();
        test_stall_read();
        test_err();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Wishbone pipelined single-beat initiator that drives the 8-bit Wishbone slave port of the network top, typically from a test sequencer or a host-side config loader.
- Accepts commands {WE, ADDR, WDATA} on a valid/ready stream.
- Issues one Wishbone transaction per command, honouring STALL, ACK and ERR.
- Returns read data and status on a valid/ready response stream.
- Per-transaction timeout so a dead slave cannot hang the initiator.

Parameters:
ADDR_WIDTH, 32, Wishbone/command address width
DATA_WIDTH, 8, Wishbone/command data width
TIMEOUT_CYCLES, 255, max cycles from first STB cycle to ACK/ERR; 0 disables timeout
TO_CNT_WIDTH, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
CMD_VALID  in  1  command valid
CMD_READY  out  1  command accepted when VALID&READY at rising edge
CMD_WE  in  1  1=write, 0=read
CMD_ADDR  in  ADDR_WIDTH  full Wishbone address (e.g. 0x3000_0000 + offset)
CMD_WDATA  in  DATA_WIDTH  write data
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed when VALID&READY
RSP_RDATA  out  DATA_WIDTH  read data (0 for writes, errors, timeouts)
RSP_ERR  out  1  slave ERR or timeout
RSP_TIMEOUT  out  1  timeout occurred
WB_CYC  out  1  cycle
WB_STB  out  1  strobe
WB_WE  out  1  write enable
WB_ADDR  out  ADDR_WIDTH  address
WB_WDATA  out  DATA_WIDTH  write data
WB_SEL  out  1  byte select
WB_STALL  in  1  slave stall
WB_ACK  in  1  slave ack
WB_RDATA  in  DATA_WIDTH  slave read data
WB_ERR  in  1  slave error
STAT_XFERS  out  16  completed transactions, incl. errors and timeouts (see Optional Feature)
STAT_ERRS  out  8  ERR terminations
STAT_TIMEOUTS  out  8  timeout terminations

Behaviour:
- Reset: all outputs 0 except CMD_READY=1; FSM=IDLE; counters 0. RST mid-transaction: CYC/STB deassert at the next edge, and any pending response is discarded (never presented).
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE: CMD_READY=1. On CMD_VALID, latch cmd into WB_WE/ADDR/WDATA; WB_SEL=1; CYC=STB=1 from the next cycle (1-cycle latency); go to REQ.
  - REQ: CYC=STB=1, CMD_READY=0.
    - STALL=1: hold all WB outputs stable.
    - STALL=0: request accepted; STB=0 next cycle.
    - ACK or ERR sampled in the accept cycle: go straight to RESP. Otherwise go to WAIT.
  - WAIT: CYC=1, STB=0. ACK or ERR: CYC=0, go to RESP.
  - RESP: RSP_VALID=1 with stable RDATA/ERR/TIMEOUT until RSP_READY. Then go to IDLE; CMD_READY=1 the following cycle.
- Response capture:
  - Read ACK: capture WB_RDATA.
  - Write ACK: RDATA=0.
  - ACK and ERR together: ERR wins, RSP_ERR=1, RDATA=0.
  - ACK/ERR sampled outside REQ/WAIT, or during REQ while STALL=1: ignored.
- Timeout:
  - Counter clears on entering REQ and increments every cycle in REQ/WAIT.
  - If TIMEOUT_CYCLES>0 and no ACK/ERR is seen during the TIMEOUT_CYCLES cycles starting at the first STB cycle T: CYC=STB=0 and RSP_VALID=1 at cycle T+TIMEOUT_CYCLES, with RSP_ERR=1, RSP_TIMEOUT=1, RDATA=0.
  - A late ACK arriving after that point is ignored.
- One outstanding transaction maximum. Back-to-back throughput with zero-wait slave and RSP_READY held high: one command per 4 cycles.

Optional Feature:
Macro WB_CMD_MASTER_STATS_EN.
- Defined: STAT_* counters increment by 1 on RESP entry, classified as completion, ERR or timeout. Counters saturate at all-ones, clear only on RST.
- Undefined: STAT_* ports are tied to 0 and no counter logic is generated.

Test Plan:
1. Write 0x5A to 0x3000_0010, slave ACKs the cycle after STB with STALL=0 -> WB_WE=1, WB_WDATA=0x5A held; RSP_VALID 3 cycles after cmd accept, RSP_ERR=0, RSP_RDATA=0x00.
2. Read 0x3000_0004, STALL=1 for 3 cycles then ACK with RDATA=0xC3 in the accept cycle -> STB/ADDR stable for 4 cycles; RSP_RDATA=0xC3, RSP_ERR=0.
3. Read with ERR and ACK asserted together -> RSP_ERR=1, RSP_TIMEOUT=0, RSP_RDATA=0x00; STAT_ERRS=1 with macro defined.
4. TIMEOUT_CYCLES=8, slave silent -> CYC drops and RSP_VALID=1 exactly 8 cycles after first STB; RSP_TIMEOUT=1, RSP_ERR=1; an ACK injected 2 cycles later is ignored.
5. RSP_READY held low 5 cycles with CMD_VALID continuously high -> RSP fields stable, CMD_READY=0 throughout; next command accepted the cycle after handshake.
6. RST asserted while in WAIT -> next edge CYC=STB=0, RSP_VALID=0, CMD_READY=1; STAT_* counters=0.
